// File: rtl/cluster_expander1536_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cluster_expander1536_if : cluster words in, rebuilt 1536-pad bitmap out.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface cluster_expander1536_if #(
  parameter int MXADRBITS = 11,
  parameter int MXCNTBITS = 3,
  parameter int MXPADS    = 1536
);
  logic                   latch_in;
  logic [8*MXADRBITS-1:0] adr_in;
  logic [8*MXCNTBITS-1:0] cnt_in;
  logic [MXPADS-1:0]      vpfs_out;
  logic                   valid_out;
  logic                   busy;
  logic                   overlap_err;
  logic                   drop_pulse;

  modport master (
    output latch_in, adr_in, cnt_in,
    input  vpfs_out, valid_out, busy, overlap_err, drop_pulse
  );

  modport slave (
    input  latch_in, adr_in, cnt_in,
    output vpfs_out, valid_out, busy, overlap_err, drop_pulse
  );
endinterface
`default_nettype wire

// File: rtl/cluster_expander1536.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cluster_expander1536 : expands 8 (adr,cnt) clusters, one per clock, into a |
// | 1536-pad bitmap. Option macro: CLUSTER_EXPANDER_EARLY_TERM_EN.  Rev 1.0    |
// +----------------------------------------------------------------------------+
module cluster_expander1536 (
  input  wire logic             clock4x,
  input  wire logic             global_reset,
  cluster_expander1536_if.slave bus
);
  localparam int MXADRBITS = 11;
  localparam int MXCNTBITS = 3;
  localparam int MXPADS    = 1536;
  localparam int NSLOTS    = 8;

  typedef enum logic [0:0] {IDLE = 1'b0, EXPAND = 1'b1} state_t;

  state_t                      state_q, state_d;
  logic [2:0]                  slot_q, slot_d;
  logic [NSLOTS*MXADRBITS-1:0] adr_q, adr_d;
  logic [NSLOTS*MXCNTBITS-1:0] cnt_q, cnt_d;
  logic [MXPADS-1:0]           vpfs_q, vpfs_d;
  logic                        valid_q, valid_d;
  logic                        acc_q, acc_d;
  logic                        err_q, err_d;
  logic                        drop_q, drop_d;

  logic [MXADRBITS-1:0] cur_adr;
  logic [MXCNTBITS-1:0] cur_cnt;
  logic [11:0]          cur_end;
  logic                 cur_empty;
  logic [MXPADS-1:0]    mask;
  logic                 hit;
  logic                 last;

  assign cur_adr   = adr_q[MXADRBITS*slot_q +: MXADRBITS];
  assign cur_cnt   = cnt_q[MXCNTBITS*slot_q +: MXCNTBITS];
  // 12-bit end so a cluster starting near 2047 cannot wrap back to low pads
  assign cur_end   = {1'b0, cur_adr} + {9'd0, cur_cnt};
  assign cur_empty = ({1'b0, cur_adr} >= 12'(MXPADS));

  always_comb begin
    mask = '0;
    for (int k = 0; k < MXPADS; k++) begin
      mask[k] = !cur_empty && (12'(k) >= {1'b0, cur_adr}) && (12'(k) <= cur_end);
    end
  end

  assign hit = |(vpfs_q & mask);

`ifdef CLUSTER_EXPANDER_EARLY_TERM_EN
  // Encoder output is ordered: the first empty slot means no more clusters
  assign last = cur_empty || (slot_q == 3'(NSLOTS - 1));
`else
  assign last = (slot_q == 3'(NSLOTS - 1));
`endif

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    adr_d   = adr_q;
    cnt_d   = cnt_q;
    vpfs_d  = vpfs_q;
    acc_d   = acc_q;
    err_d   = err_q;
    valid_d = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.latch_in) begin
          adr_d   = bus.adr_in;
          cnt_d   = bus.cnt_in;
          vpfs_d  = '0;
          acc_d   = 1'b0;
          err_d   = 1'b0;
          slot_d  = 3'd0;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        drop_d = bus.latch_in;
        vpfs_d = vpfs_q | mask;
        acc_d  = acc_q | hit;
        if (last) begin
          state_d = IDLE;
          valid_d = 1'b1;
          err_d   = acc_q | hit;
          slot_d  = 3'd0;
        end else begin
          slot_d = slot_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock4x or posedge global_reset) begin
    if (global_reset) begin
      state_q <= IDLE;
      slot_q  <= '0;
      adr_q   <= '0;
      cnt_q   <= '0;
      vpfs_q  <= '0;
      acc_q   <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      adr_q   <= adr_d;
      cnt_q   <= cnt_d;
      vpfs_q  <= vpfs_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.vpfs_out    = vpfs_q;
  assign bus.valid_out   = valid_q;
  assign bus.busy        = (state_q == EXPAND);
  assign bus.overlap_err = err_q;
  assign bus.drop_pulse  = drop_q;
endmodule
`default_nettype wire

// File: tb/tb_cluster_expander1536.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cluster_expander1536 : random and directed cluster sets against a       |
// | pad-by-pad reference bitmap.  Rev 1.0                                      |
// +----------------------------------------------------------------------------+
module tb_cluster_expander1536;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cluster_expander1536_if bus ();
  cluster_expander1536 dut (.clock4x(clk), .global_reset(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int ta[8];
  int tc[8];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_map(input string tag, input logic [1535:0] exp);
    for (int c = 0; c < 24; c++)
      check($sformatf("%s[%0d]", tag, c), bus.vpfs_out[64*c +: 64], exp[64*c +: 64]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: walk the cluster list pad by pad
  task automatic model(output logic [1535:0] m, output logic e, output int lat);
    m = '0; e = 1'b0; lat = 8;
    for (int i = 0; i < 8; i++) begin
      if (ta[i] >= 1536) begin
`ifdef CLUSTER_EXPANDER_EARLY_TERM_EN
        lat = i + 1;
        break;
`else
        continue;
`endif
      end
      for (int k = ta[i]; k <= ta[i] + tc[i]; k++) begin
        if (k < 1536) begin
          if (m[k]) e = 1'b1;
          m[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic start_txn();
    for (int i = 0; i < 8; i++) begin
      bus.adr_in[11*i +: 11] = 11'(ta[i]);
      bus.cnt_in[3*i +: 3]   = 3'(tc[i]);
    end
    bus.latch_in = 1'b1;
    step();
    bus.latch_in = 1'b0;
    check("busy_after_capture", bus.busy, 1'b1);
  endtask

  task automatic finish_txn(input string tag, input int drop_at);
    logic [1535:0] em;
    logic          ee;
    int            elat, lat, drops;
    model(em, ee, elat);
    lat = 0; drops = 0;
    while (!bus.valid_out && lat < 20) begin
      if (bus.drop_pulse) drops++;
      if (drop_at > 0 && lat == drop_at - 1) bus.latch_in = 1'b1;
      step();
      bus.latch_in = 1'b0;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(elat));
    check({tag, "_drops"}, 64'(drops), (drop_at > 0) ? 64'd1 : 64'd0);
    check({tag, "_busy_in_valid"}, bus.busy, 1'b0);
    check({tag, "_overlap"}, bus.overlap_err, ee);
    check_map({tag, "_map"}, em);
  endtask

  task automatic after_valid(input string tag);
    logic [1535:0] em;
    logic          ee;
    int            elat;
    model(em, ee, elat);
    step();
    check({tag, "_valid_one_cycle"}, bus.valid_out, 1'b0);
    check_map({tag, "_hold"}, em);
  endtask

  task automatic set_all_empty();
    for (int i = 0; i < 8; i++) begin
      ta[i] = 2047; tc[i] = 0;
    end
  endtask

  function automatic int rand_adr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 2) return 1536 + int'($urandom_range(0, 511));
    if (r == 2) return 1528 + int'($urandom_range(0, 7));
    if (r < 6) return int'($urandom_range(0, 40));
    return int'($urandom_range(0, 1535));
  endfunction

  initial begin
    logic [1535:0] em;
    logic          ee;
    int            elat, vcount, dat;

    rst = 1'b1;
    bus.latch_in = 1'b0;
    bus.adr_in = '0;
    bus.cnt_in = '0;
    step(); step();
    check("rst_valid", bus.valid_out, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_err", bus.overlap_err, 1'b0);
    check("rst_drop", bus.drop_pulse, 1'b0);
    check_map("rst_map", '0);
    rst = 1'b0;
    step();

    // Single cluster
    set_all_empty(); ta[0] = 10; tc[0] = 2;
    start_txn(); finish_txn("single", 0); after_valid("single");

    // Top clip
    set_all_empty(); ta[0] = 1534; tc[0] = 7;
    start_txn(); finish_txn("clip", 0); after_valid("clip");

    // Overlap
    set_all_empty(); ta[0] = 100; tc[0] = 3; ta[1] = 102; tc[1] = 0;
    start_txn(); finish_txn("overlap", 0); after_valid("overlap");

    // Ordering with a hole in slot 1 (early-term sensitive)
    set_all_empty(); ta[0] = 5; tc[0] = 0; ta[2] = 900; tc[2] = 1;
    start_txn(); finish_txn("hole", 0); after_valid("hole");

    // Dropped latch at E4, then a latch accepted in the valid cycle
    set_all_empty(); ta[0] = 300; tc[0] = 4; ta[1] = 766; tc[1] = 5;
    start_txn(); finish_txn("b2b_first", 4);
    for (int i = 0; i < 8; i++) begin
      ta[i] = 200 + 20 * i; tc[i] = i;
    end
    start_txn();
    check_map("b2b_cleared", '0);
    finish_txn("b2b_second", 0); after_valid("b2b_second");

    // Reset in the middle of an expansion
    for (int i = 0; i < 8; i++) begin
      ta[i] = 50 * i; tc[i] = 7;
    end
    start_txn(); step(); step(); step();
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", bus.valid_out, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_err", bus.overlap_err, 1'b0);
    check("midrst_drop", bus.drop_pulse, 1'b0);
    check_map("midrst_map", '0);
    #2 rst = 1'b0;
    vcount = 0;
    for (int n = 0; n < 15; n++) begin
      step();
      if (bus.valid_out) vcount++;
    end
    check("midrst_no_valid", 64'(vcount), 64'd0);

    // Randomized cluster sets, sometimes with a dropped latch
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 8; i++) begin
        ta[i] = rand_adr(); tc[i] = int'($urandom_range(0, 7));
      end
      model(em, ee, elat);
      dat = (elat > 1 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, elat - 1)) : 0;
      start_txn();
      finish_txn($sformatf("rnd%0d", t), dat);
      if ($urandom_range(0, 1) == 0) after_valid($sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
